// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared state encodings, PC-select codes and register-match helper for the pipeline sequencer
package mips_pipe_pkg;
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] MEM_WAIT   = 2'd1;
  localparam logic [1:0] EXC_SETTLE = 2'd2;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_VEC = 2'd2;
  localparam logic [1:0] PC_EPC = 2'd3;
  function automatic logic src_match(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt,
    input logic [4:0] dst
  );
    return (dst != 5'd0) && ((uses_rs && rs == dst) || (uses_rt && rt == dst));
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard comparator
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic       branch,
  input  logic       ex_lw,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_dst,
  input  logic       mem_lw,
  input  logic [4:0] mem_dst,
  output logic       lu,
  output logic       bo
);
  assign lu = ex_lw & src_match(rs, rt, uses_rs, uses_rt, ex_dst);
  assign bo = branch & ((ex_regwrite & src_match(rs, rt, uses_rs, uses_rt, ex_dst)) |
                        (mem_lw & src_match(rs, rt, uses_rs, uses_rt, mem_dst)));
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/PC-select controller for the 5-stage MIPS32 pipeline
module pipeline_sequencer
  import mips_pipe_pkg::*;
#(
  parameter bit DELAY_SLOT  = 1'b1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_s_rst,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_id_branch,
  input  logic       i_id_taken,
  input  logic       i_id_eret,
  input  logic       i_ex_lw,
  input  logic       i_ex_regwrite,
  input  logic [4:0] i_ex_dst,
  input  logic       i_mem_lw,
  input  logic [4:0] i_mem_dst,
  input  logic       i_dmem_req,
  input  logic       i_dmem_ready,
  input  logic       i_exc,
  output logic       o_we_fetch,
  output logic       o_we_decode,
  output logic       o_we_exec,
  output logic       o_we_MemAc,
  output logic       o_we_WrBc,
  output logic       o_s_rst_decode,
  output logic       o_s_rst_exec,
  output logic       o_s_rst_MemAc,
  output logic       o_s_rst_WrBc,
  output logic [1:0] o_pc_sel,
  output logic       o_epc_we,
  output logic       o_dmem_abort,
  output logic       o_bus_err,
  output logic [1:0] o_state
);
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MEM_TIMEOUT - 1);
  logic [1:0] st, st_nxt;
  logic [CW-1:0] cnt;
  logic lu, bo, in_wait, in_settle, in_run, timeout;
  logic entry, freeze, pipe, stall, eret, br;
  hazard_detect u_hazard (
    .rs(i_id_rs),
    .rt(i_id_rt),
    .uses_rs(i_id_uses_rs),
    .uses_rt(i_id_uses_rt),
    .branch(i_id_branch),
    .ex_lw(i_ex_lw),
    .ex_regwrite(i_ex_regwrite),
    .ex_dst(i_ex_dst),
    .mem_lw(i_mem_lw),
    .mem_dst(i_mem_dst),
    .lu(lu),
    .bo(bo)
  );
  assign in_wait   = st == MEM_WAIT;
  assign in_settle = st == EXC_SETTLE;
  assign in_run    = !in_wait && !in_settle;
  assign timeout   = (MEM_TIMEOUT != 0) && (cnt == CMAX);
  assign entry     = ((in_run || in_wait) && i_exc) || (in_wait && !i_dmem_ready && timeout);
  assign freeze    = !entry && ((in_run && i_dmem_req && !i_dmem_ready) || (in_wait && !i_dmem_ready));
  assign pipe      = !entry && !freeze && !in_settle;
  assign stall     = in_settle || (pipe && (lu || bo));
  assign eret      = pipe && !(lu || bo) && i_id_eret;
  assign br        = pipe && !(lu || bo) && !i_id_eret && i_id_taken;
  // state and wait counter; the counter restarts on every entry to MEM_WAIT and saturates
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= !in_wait ? '0 : (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    end
  end
  // next state: exception entry beats a memory freeze, everything else returns to RUN
  always_comb begin
    st_nxt = entry ? EXC_SETTLE : freeze ? MEM_WAIT : RUN;
  end
  // per-stage enables, clears and pulses; reset forces every stage to clear
  always_comb begin
    o_we_fetch     = !i_s_rst && !freeze && !stall;
    o_we_decode    = !i_s_rst && !freeze && !stall;
    o_we_exec      = !i_s_rst && !freeze;
    o_we_MemAc     = !i_s_rst && !freeze;
    o_we_WrBc      = !i_s_rst && !freeze;
    o_s_rst_decode = i_s_rst || entry || eret || (br && !DELAY_SLOT);
    o_s_rst_exec   = i_s_rst || entry || stall;
    o_s_rst_MemAc  = i_s_rst || entry;
    o_s_rst_WrBc   = i_s_rst;
    o_pc_sel       = i_s_rst ? PC_SEQ : entry ? PC_VEC : eret ? PC_EPC : br ? PC_BR : PC_SEQ;
    o_epc_we       = !i_s_rst && entry;
    o_dmem_abort   = !i_s_rst && entry && in_wait;
    o_bus_err      = !i_s_rst && in_wait && !i_exc && !i_dmem_ready && timeout;
    o_state        = i_s_rst ? RUN : st;
  end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush/PC-select controller for the 5-stage MIPS32 pipeline. Each cycle it decides which pipeline registers load and which are cleared. It drives the per-stage write enables and synchronous clears of the fetch, decode, execute, memory-access and write-back registers, including the stage control registers. It detects load-use and branch-operand hazards, freezes the pipe on data-memory wait states with a timeout, and sequences exception entry and `eret` return.

## Interface
- `DELAY_SLOT`, default 1: 1 means the instruction after a taken branch/jump executes; 0 means it is cleared.
- `MEM_TIMEOUT`, default 16: maximum MEM_WAIT cycles before a bus error; 0 disables the timeout.
- `i_clk` in 1: the single clock.
- `i_s_rst` in 1: synchronous, active-high reset.
- `i_id_rs`, `i_id_rt` in 5: source registers of the decode-stage instruction.
- `i_id_uses_rs`, `i_id_uses_rt` in 1: the decode instruction reads rs / rt.
- `i_id_branch` in 1: the decode instruction is beq/bne/jr, which needs operands in decode.
- `i_id_taken` in 1: branch taken, j, or jr resolved in decode.
- `i_id_eret` in 1: the decode instruction is eret.
- `i_ex_lw`, `i_ex_regwrite` in 1, `i_ex_dst` in 5: execute-stage load flag, register-write flag and destination.
- `i_mem_lw` in 1, `i_mem_dst` in 5: memory-access-stage load flag and destination.
- `i_dmem_req`, `i_dmem_ready` in 1: data-memory access in progress, and access completes this cycle.
- `i_exc` in 1: exception request (interrupt/overflow/syscall).
- `o_we_fetch`, `o_we_decode`, `o_we_exec`, `o_we_MemAc`, `o_we_WrBc` out 1: stage write enables. `o_we_fetch` is the PC write.
- `o_s_rst_decode`, `o_s_rst_exec`, `o_s_rst_MemAc`, `o_s_rst_WrBc` out 1: stage synchronous clears (bubble insertion).
- `o_pc_sel` out 2: 0 = PC+4, 1 = branch/jump target, 2 = exception vector, 3 = EPC.
- `o_epc_we` out 1: capture EPC and cause.
- `o_dmem_abort` out 1: cancel the outstanding data access.
- `o_bus_err` out 1: one-cycle pulse on memory timeout.
- `o_state` out 2: current FSM state, for debug.

## Operation
- FSM states: RUN = 0, MEM_WAIT = 1, EXC_SETTLE = 2. Value 3 is unused and treated as RUN.
- All outputs are combinational from the state, the counter and the inputs. Default values: all `we` = 1, all `s_rst` = 0, `o_pc_sel` = 0, pulse outputs = 0.
- Load-use stall (`lu`): `i_ex_lw` & `i_ex_dst`≠0 & ((`uses_rs` & rs==`ex_dst`) | (`uses_rt` & rt==`ex_dst`)).
- Branch-operand stall (`bo`): `i_id_branch` & ((`i_ex_regwrite` & `ex_dst`≠0 & match) | (`i_mem_lw` & `mem_dst`≠0 & match)). "Match" is the same rs/rt comparison against the respective destination.
- Priorities in RUN, highest first:
  1. `i_exc` takes exception entry: `o_epc_we`=1, `pc_sel`=2, clear decode/exec/MemAc, `we_WrBc`=1 so the older instruction retires. Next state EXC_SETTLE.
  2. `i_dmem_req` & !`i_dmem_ready` freezes the pipe: all `we`=0, all `s_rst`=0. Next state MEM_WAIT, counter cleared to 0.
  3. `lu` | `bo` stalls: `we_fetch`=`we_decode`=0, `s_rst_exec`=1. `i_id_taken` and `i_id_eret` are ignored while stalled.
  4. `i_id_eret` returns: `pc_sel`=3, `s_rst_decode`=1.
  5. `i_id_taken` redirects: `pc_sel`=1. `s_rst_decode`=1 only when `DELAY_SLOT`=0.
- MEM_WAIT:
  - `i_exc` takes exception entry as above, plus `o_dmem_abort`=1.
  - Otherwise, `i_dmem_ready` applies RUN priorities 3–5 this cycle and the next state is RUN.
  - Otherwise, timeout (counter == `MEM_TIMEOUT`−1, `MEM_TIMEOUT`≠0) takes exception entry with `o_bus_err`=1 and `o_dmem_abort`=1.
  - Otherwise the pipe stays frozen and the counter increments.
- EXC_SETTLE, exactly one cycle for the CP0 status/cause write: `we_fetch`=`we_decode`=0, `s_rst_exec`=1, `i_exc` is ignored. Next state RUN.
- Counter width is $clog2(`MEM_TIMEOUT`+1), minimum 1. It saturates and never wraps.

## Timing
- While `i_s_rst`=1:
  - The state goes to RUN and the counter to 0 at the clock edge.
  - Outputs are forced: all `we`=0, all `s_rst`=1, `pc_sel`=0, `epc_we`=`dmem_abort`=`bus_err`=0, `o_state`=0.
- Reset asserted mid-MEM_WAIT or mid-EXC_SETTLE returns to RUN at the next edge with no pulses.
- Stall and flush decisions are zero-latency, in the same cycle as the inputs. State changes take effect at the next edge.
- A load-use stall inserts exactly one bubble. A branch-operand stall lasts until the producer leaves EX/MemAc (1–2 cycles).
- Total frozen cycles on a timeout = 1 (RUN detect) + `MEM_TIMEOUT`. The `o_bus_err` pulse occurs in the last of them.
- Exception entry to first vector fetch: 1 cycle, then 1 EXC_SETTLE cycle.
- Simultaneous events resolve strictly by the priority list: exception > memory wait > hazard > eret > branch.

## Structure
- Package `mips_pipe_pkg` holds:
  - the state encoding localparams (RUN, MEM_WAIT, EXC_SETTLE);
  - the `o_pc_sel` codes (PC_SEQ, PC_BR, PC_VEC, PC_EPC).
- Sub-module `hazard_detect` is the combinational comparator producing `lu` and `bo`.
- The FSM, counter and output decode live in `pipeline_sequencer`.

## Test plan
- Load-use: `ex_lw`=1, `ex_dst`=5, `id_rs`=5, `uses_rs`=1 → one cycle of `we_fetch`=`we_decode`=0, `s_rst_exec`=1. With `ex_dst`=0 → no stall.
- Branch operand: beq with rt=7 while `ex_regwrite`=1, `ex_dst`=7, then the next cycle `mem_lw`=1, `mem_dst`=7 → 2 stall cycles, then `pc_sel`=1 with `i_id_taken`=1.
- Memory wait: req=1, ready low for 3 cycles → 4 frozen cycles, `o_state`=1, resume on ready. `MEM_TIMEOUT`=4 with ready never asserted → `bus_err` and `dmem_abort` pulse in frozen cycle 5, then `pc_sel`=2 and `epc_we` in that cycle, EXC_SETTLE, RUN.
- Exception vs branch: `i_exc`=1 and `i_id_taken`=1 together → `pc_sel`=2, `epc_we`=1, decode/exec/MemAc cleared, `we_WrBc`=1.
- eret with `DELAY_SLOT`=0 and 1: `pc_sel`=3 and `s_rst_decode`=1. Taken branch → `s_rst_decode`=1 only when `DELAY_SLOT`=0.
- Reset in MEM_WAIT at counter=2 → RUN next edge, all `s_rst`=1 while reset is high, counter=0 after release.
